key_debounce_array: RTL

//  Parametrised N-channel push-button debouncer: next-generation key filter for all board keys.
//  Per channel: sync raw pin, debounce press and release independently, present clean level

---
 rtl/key_debounce_array.sv | 121 ++++++++++++
 1 files changed

// File: rtl/key_debounce_array.sv
// key_debounce_array: N-channel key debouncer with clean level and press/release pulses.
// Define KEY_LONG_PRESS_EN to add a one-shot long-press pulse on key_long.
module key_debounce_array #(
    parameter int NUM_KEYS          = 4,
    parameter int DEBOUNCE_CYCLES   = 1_000_000,
    parameter int ACTIVE_LOW        = 1,
    parameter int LONG_PRESS_CYCLES = 50_000_000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] key_pin,
    output logic [NUM_KEYS-1:0] key_status,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] key_long
);
    localparam int MAX_CYC = DEBOUNCE_CYCLES > LONG_PRESS_CYCLES ? DEBOUNCE_CYCLES : LONG_PRESS_CYCLES;
    localparam int CW = $clog2(MAX_CYC + 1);
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic REL = (ACTIVE_LOW != 0);
    typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;
    logic [NUM_KEYS-1:0] sync1, sync2, s;
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= {NUM_KEYS{REL}};
            sync2 <= {NUM_KEYS{REL}};
        end else begin
            sync1 <= key_pin;
            sync2 <= sync1;
        end
    end
    assign s = sync2 ^ {NUM_KEYS{REL}};
    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_ch
        state_t state;
        logic [CW-1:0] cnt;
        logic status, press, rel_p;
`ifdef KEY_LONG_PRESS_EN
        localparam logic [CW-1:0] LP_LAST = CW'(LONG_PRESS_CYCLES - 1);
        logic long_p, long_done;
`endif
        always_ff @(posedge clk) begin
            press <= 1'b0;
            rel_p <= 1'b0;
`ifdef KEY_LONG_PRESS_EN
            long_p <= 1'b0;
`endif
            if (rst) begin
                state  <= IDLE;
                cnt    <= '0;
                status <= 1'b0;
`ifdef KEY_LONG_PRESS_EN
                long_done <= 1'b0;
`endif
            end else begin
                case (state)
                    IDLE: begin
                        state <= s[k] ? PRESS_WAIT : IDLE;
                        cnt   <= s[k] ? CW'(1) : '0;
                    end
                    PRESS_WAIT: begin
                        if (!s[k]) begin
                            state <= IDLE;
                            cnt   <= '0;
                        end else if (cnt == DB_LAST) begin
                            state  <= HELD;
                            status <= 1'b1;
                            press  <= 1'b1;
                            cnt    <= '0;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    HELD: begin
                        if (!s[k]) begin
                            state <= RELEASE_WAIT;
                            cnt   <= CW'(1);
                        end
`ifdef KEY_LONG_PRESS_EN
                        else begin
                            if (cnt != '1) cnt <= cnt + CW'(1);
                            if (cnt == LP_LAST && !long_done) begin
                                long_p    <= 1'b1;
                                long_done <= 1'b1;
                            end
                        end
`endif
                    end
                    RELEASE_WAIT: begin
                        if (s[k]) begin
                            state <= HELD;
                            cnt   <= '0;
                        end else if (cnt == DB_LAST) begin
                            state  <= IDLE;
                            status <= 1'b0;
                            rel_p  <= 1'b1;
                            cnt    <= '0;
`ifdef KEY_LONG_PRESS_EN
                            long_done <= 1'b0;
`endif
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    default: begin
                        state  <= IDLE;
                        cnt    <= '0;
                        status <= 1'b0;
                    end
                endcase
            end
        end
        assign key_status[k]  = status;
        assign key_press[k]   = press;
        assign key_release[k] = rel_p;
`ifdef KEY_LONG_PRESS_EN
        assign key_long[k] = long_p;
`else
        assign key_long[k] = 1'b0;
`endif
    end
endmodule
